random_sequence: RTL and testbench

Parametrised random-symbol sequence generator for the game cores: a free-running LFSR supplies entropy, and on request the block draws one symbol in the range 0..NUM_SYMBOLS-1 and appends it to an internal sequence buffer. Draws can optionally forbid immediate repeats. The game FSM reads any stored element back by index for playback and comparison. It replaces the fixed 2/3-bit address generator for all games that need growing random sequences.

---
 rtl/random_pkg.sv | 35 +++
 rtl/random_sequence_lfsr_core.sv | 37 +++
 rtl/random_sequence.sv | 149 ++++++++++++++
 tb/tb_random_sequence.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_pkg.sv
// Shared definitions for random_sequence: LFSR tap masks, FSM state encoding
// and the fallback-symbol rule used when every draw attempt is rejected.
package random_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DRAW = 1'b1;

    // Maximal-length Fibonacci taps; bit n-1 is set for polynomial tap n.
    function automatic logic [15:0] lfsr_taps(input int width);
        logic [15:0] taps;
        case (width)
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            default: taps = 16'hD008;
        endcase
        return taps;
    endfunction

    // (last + 1) mod num_symbols, written as a compare so no divider is built.
    function automatic int unsigned fallback_symbol(input int unsigned last,
                                                    input logic        has_last,
                                                    input int unsigned num_symbols);
        if (!has_last) begin
            return 0;
        end
        return (last + 1 >= num_symbols) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/random_sequence_lfsr_core.sv
// Free-running Fibonacci LFSR; steps every clock and escapes the all-zero
// lock-up state by jumping to 1.
module lfsr_core
    import random_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] lfsr
);
    localparam logic [WIDTH-1:0] TAPS        = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] RESET_VALUE = (SEED == {WIDTH{1'b0}}) ? {WIDTH{1'b1}} : SEED;

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    always_comb begin
        if (state_q == {WIDTH{1'b0}}) begin
            state_d = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            state_d = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RESET_VALUE;
        end else begin
            state_q <= state_d;
        end
    end

    assign lfsr = state_q;

endmodule

// File: rtl/random_sequence.sv
// Growing random-symbol sequence: draws symbols from a free-running LFSR on
// request and appends them to a length-masked buffer readable by index.
module random_sequence
    import random_pkg::*;
#(
    parameter int                    SYM_WIDTH   = 3,
    parameter int                    NUM_SYMBOLS = 8,
    parameter int                    LFSR_WIDTH  = 8,
    parameter logic [LFSR_WIDTH-1:0] SEED        = LFSR_WIDTH'(1),
    parameter int                    DEPTH       = 16,
    parameter int                    NO_REPEAT   = 0,
    parameter int                    MAX_TRIES   = 8,
    localparam int                   IDX_W       = $clog2(DEPTH),
    localparam int                   LEN_W       = $clog2(DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 append,
    input  logic [IDX_W-1:0]     rd_index,
    output logic [SYM_WIDTH-1:0] rd_symbol,
    output logic [SYM_WIDTH-1:0] last_symbol,
    output logic [LEN_W-1:0]     length,
    output logic                 busy,
    output logic                 full,
    output logic                 append_done,
    output logic                 overflow
);
    // Handshake: append is a request sampled only while idle (busy low); it is
    // answered by exactly one append_done or overflow pulse, never queued.
    localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    logic [LFSR_WIDTH-1:0] lfsr_state;
    logic                  unused_lfsr_bits;
    logic [SYM_WIDTH-1:0]  candidate;
    logic [SYM_WIDTH-1:0]  fallback;
    logic [SYM_WIDTH-1:0]  wr_symbol;
    logic                  cand_accept;
    logic                  mem_we;

    logic [0:0]           state_q, state_d;
    logic [LEN_W-1:0]     length_q, length_d;
    logic [SYM_WIDTH-1:0] last_q, last_d;
    logic [TRY_W-1:0]     tries_q, tries_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic [SYM_WIDTH-1:0] rd_q, rd_d;

    logic [SYM_WIDTH-1:0] mem [DEPTH];

    lfsr_core #(
        .WIDTH (LFSR_WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr_state)
    );

    assign unused_lfsr_bits = ^lfsr_state;
    assign candidate = lfsr_state[SYM_WIDTH-1:0] ^ lfsr_state[LFSR_WIDTH-1 -: SYM_WIDTH];
    assign fallback  = SYM_WIDTH'(fallback_symbol(32'(last_q), length_q != '0, NUM_SYMBOLS));
    assign full      = (length_q == DEPTH_LEN);

    always_comb begin
        cand_accept = (int'(candidate) < NUM_SYMBOLS) &&
                      !((NO_REPEAT != 0) && (length_q != '0) && (candidate == last_q));
        wr_symbol   = cand_accept ? candidate : fallback;
    end

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        last_d   = last_q;
        tries_d  = tries_q;
        done_d   = 1'b0;
        ovf_d    = 1'b0;
        mem_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (append && !full) begin
                    state_d = ST_DRAW;
                    tries_d = '0;
                end else if (append) begin
                    ovf_d = 1'b1;
                end
            end
            default: begin
                if (cand_accept || (tries_q == LAST_TRY)) begin
                    mem_we   = 1'b1;
                    length_d = length_q + 1'b1;
                    last_d   = wr_symbol;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
        endcase
        // Clear overrides everything, including a draw completing this cycle.
        if (clear) begin
            state_d  = ST_IDLE;
            length_d = '0;
            last_d   = '0;
            tries_d  = '0;
            done_d   = 1'b0;
            ovf_d    = 1'b0;
            mem_we   = 1'b0;
        end
        rd_d = (LEN_W'(rd_index) < length_q) ? mem[rd_index] : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            length_q <= '0;
            last_q   <= '0;
            tries_q  <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            last_q   <= last_d;
            tries_q  <= tries_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            rd_q     <= rd_d;
        end
    end

    // Buffer contents are never reset; length masks stale entries on read.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[length_q[IDX_W-1:0]] <= wr_symbol;
        end
    end

    assign rd_symbol   = rd_q;
    assign last_symbol = last_q;
    assign length      = length_q;
    assign busy        = (state_q == ST_DRAW);
    assign append_done = done_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_random_sequence.sv
// Self-checking bench for random_sequence: three configurations share the
// stimulus, and a behavioural model predicts symbols and draw latencies.
module tb_random_sequence;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       clear  = 1'b0;
    logic       append = 1'b0;
    logic [3:0] rd_idx = 4'd0;

    // a: SEED=0, DEPTH=4; b: 5 symbols, no repeats; c: 2 symbols, single try
    logic [2:0] a_rd, a_last, a_len;
    logic       a_busy, a_full, a_done, a_ovf;
    logic [2:0] b_rd, b_last;
    logic [4:0] b_len;
    logic       b_busy, b_full, b_done, b_ovf;
    logic       c_rd, c_last;
    logic [4:0] c_len;
    logic       c_busy, c_full, c_done, c_ovf;

    int          sel = 0;
    logic [31:0] s_rd, s_last, s_len, s_busy, s_full, s_done, s_ovf;

    int cfg_symw  [3] = '{3, 3, 1};
    int cfg_nsym  [3] = '{8, 5, 2};
    int cfg_norep [3] = '{0, 1, 1};
    int cfg_tries [3] = '{8, 8, 1};
    int cfg_depth [3] = '{4, 16, 16};
    // A zero seed must behave as all-ones.
    logic [7:0] m_seed [3] = '{8'hFF, 8'hA5, 8'h5A};
    logic [7:0] m_lfsr [3];

    logic [3:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    random_sequence #(.SYM_WIDTH(3), .NUM_SYMBOLS(8), .LFSR_WIDTH(8), .SEED(8'h00),
                      .DEPTH(4), .NO_REPEAT(0), .MAX_TRIES(8)) u_a (
        .clock(clock), .reset(reset), .clear(clear), .append(append),
        .rd_index(rd_idx[1:0]), .rd_symbol(a_rd), .last_symbol(a_last), .length(a_len),
        .busy(a_busy), .full(a_full), .append_done(a_done), .overflow(a_ovf));

    random_sequence #(.SYM_WIDTH(3), .NUM_SYMBOLS(5), .LFSR_WIDTH(8), .SEED(8'hA5),
                      .DEPTH(16), .NO_REPEAT(1), .MAX_TRIES(8)) u_b (
        .clock(clock), .reset(reset), .clear(clear), .append(append),
        .rd_index(rd_idx), .rd_symbol(b_rd), .last_symbol(b_last), .length(b_len),
        .busy(b_busy), .full(b_full), .append_done(b_done), .overflow(b_ovf));

    random_sequence #(.SYM_WIDTH(1), .NUM_SYMBOLS(2), .LFSR_WIDTH(8), .SEED(8'h5A),
                      .DEPTH(16), .NO_REPEAT(1), .MAX_TRIES(1)) u_c (
        .clock(clock), .reset(reset), .clear(clear), .append(append),
        .rd_index(rd_idx), .rd_symbol(c_rd), .last_symbol(c_last), .length(c_len),
        .busy(c_busy), .full(c_full), .append_done(c_done), .overflow(c_ovf));

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic do_reset(input int s);
        sel    = s;
        append = 1'b0;
        clear  = 1'b0;
        reset  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.delete();
    endtask

    always_comb begin
        case (sel)
            0: begin
                s_rd = 32'(a_rd); s_last = 32'(a_last); s_len = 32'(a_len); s_busy = 32'(a_busy);
                s_full = 32'(a_full); s_done = 32'(a_done); s_ovf = 32'(a_ovf);
            end
            1: begin
                s_rd = 32'(b_rd); s_last = 32'(b_last); s_len = 32'(b_len); s_busy = 32'(b_busy);
                s_full = 32'(b_full); s_done = 32'(b_done); s_ovf = 32'(b_ovf);
            end
            default: begin
                s_rd = 32'(c_rd); s_last = 32'(c_last); s_len = 32'(c_len); s_busy = 32'(c_busy);
                s_full = 32'(c_full); s_done = 32'(c_done); s_ovf = 32'(c_ovf);
            end
        endcase
    end

    // ---------------- reference model ----------------
    // Polynomial x^8 + x^6 + x^5 + x^4, shifting left with feedback into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        if (s == 8'h00) return 8'h01;
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int unsigned cand_of(input logic [7:0] s, input int symw);
        int unsigned v = 32'(s);
        int unsigned m = (32'd1 << symw) - 1;
        return (v & m) ^ ((v >> (8 - symw)) & m);
    endfunction

    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) m_lfsr[i] <= m_seed[i];
            else       m_lfsr[i] <= lfsr_next(m_lfsr[i]);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- drivers ----------------
    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check_eq(tag, s_done | s_ovf | s_busy, 0);
        end
    endtask

    task automatic check_read(input int idx);
        rd_idx = 4'(idx);
        @(negedge clock);
        check_eq("read", s_rd, (idx < exp_q.size()) ? 32'(exp_q[idx]) : 32'd0);
    endtask

    // Called on a falling edge with the DUT idle; returns on the falling edge
    // where append_done (or overflow) is visible.
    task automatic do_append();
        logic [7:0]  l;
        int unsigned nsym, last, sym, cand;
        int          lat, edges;
        bit          has_last, full_now;
        nsym     = cfg_nsym[sel];
        has_last = exp_q.size() > 0;
        last     = has_last ? 32'(exp_q[exp_q.size()-1]) : 0;
        full_now = (exp_q.size() == cfg_depth[sel]);
        l   = m_lfsr[sel];
        lat = 0;
        sym = 0;
        for (int t = 0; t < cfg_tries[sel] && lat == 0; t++) begin
            l    = lfsr_next(l);
            cand = cand_of(l, cfg_symw[sel]);
            if (cand < nsym && !(cfg_norep[sel] != 0 && has_last && cand == last)) begin
                sym = cand;
                lat = t + 2;
            end
        end
        if (lat == 0) begin
            sym = has_last ? (last + 1) % nsym : 0;
            lat = cfg_tries[sel] + 1;
        end
        append = 1'b1;
        @(negedge clock);
        append = 1'b0;
        edges  = 1;
        if (full_now) begin
            check_eq("ovf_pulse", s_ovf, 1);
            check_eq("ovf_no_done", s_done, 0);
            check_eq("ovf_not_busy", s_busy, 0);
            @(negedge clock);
            check_eq("ovf_single", s_ovf, 0);
            check_eq("ovf_len", s_len, exp_q.size());
        end else begin
            check_eq("draw_busy", s_busy, 1);
            while (s_done !== 32'd1 && edges < lat + 4) begin
                @(negedge clock);
                edges++;
            end
            check_eq("draw_latency", edges, lat);
            exp_q.push_back(4'(sym));
            check_eq("draw_symbol", s_last, sym);
            check_eq("draw_len", s_len, exp_q.size());
            check_eq("draw_idle", s_busy, 0);
            check_eq("draw_no_ovf", s_ovf, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] prev;
        bit          found;

        // Reset, zero seed, quiet outputs
        do_reset(0);
        check_eq("seed_allones", 32'(u_a.lfsr_state), 32'hFF);
        check_eq("reset_len", s_len, 0);
        check_eq("reset_rd", s_rd, 0);
        check_eq("reset_last", s_last, 0);
        check_eq("reset_full", s_full, 0);
        idle(20, "reset_quiet");
        check_eq("reset_len_after", s_len, 0);

        // Fill to DEPTH=4, then overflow
        for (int i = 0; i < 4; i++) begin
            do_append();
            check_eq("fill_full", s_full, (i == 3) ? 1 : 0);
            idle(10, "fill_gap");
        end
        do_append();
        for (int i = 0; i < 4; i++) check_read(i);

        // Read port masking and read-before-write
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        exp_q.delete();
        check_eq("clear_len", s_len, 0);
        check_eq("clear_full", s_full, 0);
        do_append();
        do_append();
        check_read(3);
        rd_idx = 4'd2;
        do_append();
        check_eq("rd_same_edge", s_rd, 0);
        @(negedge clock);
        check_eq("rd_next_edge", s_rd, 32'(exp_q[2]));

        // Clear in the cycle after append
        append = 1'b1;
        @(negedge clock);
        append = 1'b0;
        check_eq("cd_busy", s_busy, 1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        exp_q.delete();
        check_eq("cd_len", s_len, 0);
        check_eq("cd_busy_low", s_busy, 0);
        check_eq("cd_no_done", s_done, 0);
        idle(5, "cd_quiet");
        do_append();
        check_read(0);

        // Range and repeat rejection with random spacing
        do_reset(1);
        prev = 0;
        for (int i = 0; i < 16; i++) begin
            idle($urandom_range(0, 3), "b_gap");
            do_append();
            check_eq("b_range", (s_last < 5) ? 1 : 0, 1);
            if (i > 0) check_eq("b_no_repeat", (s_last != prev) ? 1 : 0, 1);
            prev = s_last;
        end
        check_eq("b_full", s_full, 1);
        for (int i = 0; i < 16; i++) check_read(i);
        do_append();

        // Fallback: last=1 and the next candidate is 1
        do_reset(2);
        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0 || exp_q[exp_q.size()-1] != 4'd1) do_append();
        end
        check_eq("fb_setup_last", s_last, 1);
        found = 1'b0;
        for (int w = 0; w < 200 && !found; w++) begin
            if (cand_of(lfsr_next(m_lfsr[2]), 1) == 1) found = 1'b1;
            else @(negedge clock);
        end
        check_eq("fb_setup_cand", found ? 1 : 0, 1);
        do_append();
        check_eq("fb_symbol", s_last, 0);
        idle(3, "fb_quiet");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, expected finish within 30000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
